// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package reg_file_mp_pkg;

    localparam int RF_XLEN   = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;
    localparam int RF_BYPASS = 1;

    function automatic int pow2(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write busy bits: set on issue, cleared by writeback, set wins.
module reg_file_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int NUM_WR     = RF_NUM_WR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_set,
    input  logic [ADDR_WIDTH-1:0]        i_set_adr,
    input  logic [NUM_WR-1:0]            i_clr,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_clr_adr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_qry_adr,
    output logic [NUM_RD-1:0]            o_busy
);

    localparam int DEPTH = pow2(ADDR_WIDTH);

    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_nxt;
    logic [ADDR_WIDTH-1:0] w_cadr [NUM_WR];

    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_clr
            assign w_cadr[j] = i_clr_adr[j*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // Clears first, then set, so a newly issued producer overrides writeback.
    always_comb begin
        w_nxt = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_clr[j] && (w_cadr[j] != '0)) begin
                w_nxt[w_cadr[j]] = 1'b0;
            end
        end
        if (i_set && (i_set_adr != '0)) begin
            w_nxt[i_set_adr] = 1'b1;
        end
        w_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_nxt;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_qry
            assign o_busy[i] = r_busy[i_qry_adr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: prioritised writes, optional bypass, x0 hardwired.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int NUM_WR     = RF_NUM_WR,
    parameter int BYPASS     = RF_BYPASS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_adr,
    output logic [NUM_RD*XLEN-1:0]       rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_adr,
    input  logic [NUM_WR*XLEN-1:0]       wr_data,
    input  logic                         sb_set,
    input  logic [ADDR_WIDTH-1:0]        sb_adr
);

    localparam int DEPTH = pow2(ADDR_WIDTH);

    logic [XLEN-1:0]       r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_wadr [NUM_WR];
    logic [XLEN-1:0]       w_wdat [NUM_WR];
    logic [NUM_WR-1:0]     w_wen;
    logic [NUM_RD-1:0]     w_busy_q;

    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
            assign w_wadr[j] = wr_adr[j*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdat[j] = wr_data[j*XLEN +: XLEN];
            assign w_wen[j]  = we[j] && (w_wadr[j] != '0);
        end
    endgenerate

    // Ascending port order: the last assignment, the highest port, wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wen[j]) begin
                    r_mem[w_wadr[j]] <= w_wdat[j];
                end
            end
        end
    end

    reg_file_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (sb_set),
        .i_set_adr (sb_adr),
        .i_clr     (w_wen),
        .i_clr_adr (wr_adr),
        .i_qry_adr (rd_adr),
        .o_busy    (w_busy_q)
    );

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_radr;
            logic [XLEN-1:0]       w_fwd;
            logic                  w_match;

            assign w_radr = rd_adr[i*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                w_match = 1'b0;
                w_fwd   = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wen[j] && (w_wadr[j] == w_radr)) begin
                        w_match = 1'b1;
                        w_fwd   = w_wdat[j];
                    end
                end
            end

            // Outputs are forced low during reset so bypass cannot leak data.
            assign rd_data[i*XLEN +: XLEN] =
                (!rst_n || (w_radr == '0)) ? '0 :
                ((BYPASS != 0) && w_match) ? w_fwd :
                r_mem[w_radr];

            assign rd_busy[i] = rst_n && w_busy_q[i] &&
                                !((BYPASS != 0) && w_match);
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench: two instances (bypass on / off) against a register model.
module tb_reg_file_mp;

    localparam int XL = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] rd_adr;
    logic [NR*XL-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    busy_b, busy_n;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wr_adr;
    logic [NW*XL-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_adr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XL-1:0] m_reg [32];
    bit            m_busy [32];

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_RD(NR),
                  .NUM_WR(NW), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_adr(rd_adr), .rd_data(rd_data_b),
        .rd_busy(busy_b), .we(we), .wr_adr(wr_adr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_adr(sb_adr));

    reg_file_mp #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_RD(NR),
                  .NUM_WR(NW), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rd_adr(rd_adr), .rd_data(rd_data_n),
        .rd_busy(busy_n), .we(we), .wr_adr(wr_adr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_adr(sb_adr));

    function automatic int wa(int j);
        return int'(wr_adr[j*AW +: AW]);
    endfunction

    function automatic int ra(int i);
        return int'(rd_adr[i*AW +: AW]);
    endfunction

    // Index of the highest enabled port writing address a, or -1.
    function automatic int winner(int a);
        int w = -1;
        for (int j = 0; j < NW; j++)
            if (we[j] && a != 0 && wa(j) == a) w = j;
        return w;
    endfunction

    function automatic logic [XL-1:0] exp_data(bit byp, int a);
        int w = winner(a);
        if (!rst_n || a == 0) return '0;
        if (byp && w >= 0) return wr_data[w*XL +: XL];
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(bit byp, int a);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && winner(a) >= 0) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [XL-1:0] dat(bit byp, int i);
        return byp ? rd_data_b[i*XL +: XL] : rd_data_n[i*XL +: XL];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Advance one clock, apply the edge to the model, return mid-low phase.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa(j) != 0) begin
                    m_reg[wa(j)]  = wr_data[j*XL +: XL];
                    m_busy[wa(j)] = 1'b0;
                end
            end
            if (sb_set && sb_adr != 0) m_busy[sb_adr] = 1'b1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wr_adr = '0; wr_data = '0; sb_set = 1'b0; sb_adr = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) rd_adr[i*AW +: AW] = AW'(i + 4);
        #1;
        for (int i = 0; i < NR; i++) begin
            n_checks += 2;
            if (dat(1, i) !== '0 || dat(0, i) !== '0) begin
                n_fail++;
                $display("FAIL reset_data port %0d got %h/%h need 0",
                         i, dat(1, i), dat(0, i));
            end
            if (busy_b[i] !== 1'b0 || busy_n[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy port %0d got %b/%b need 0",
                         i, busy_b[i], busy_n[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        we = 2'b01; wr_adr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h12345678};
        sb_set = 1'b1; sb_adr = 5'd6;
        tick();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks += 2;
        if (dat(1, 1) !== '0 || dat(0, 1) !== '0) begin
            n_fail++;
            $display("FAIL reset_async_data got %h/%h need 0",
                     dat(1, 1), dat(0, 1));
        end
        if (busy_b !== '0 || busy_n !== '0) begin
            n_fail++;
            $display("FAIL reset_async_busy got %b/%b need 0", busy_b, busy_n);
        end
        idle();
        #1 rst_n = 1'b1;
        tick();
        rd_adr[0 +: AW] = 5'd5;
        rd_adr[AW +: AW] = 5'd6;
        #1;
        n_checks += 2;
        if (dat(1, 0) !== '0 || dat(0, 0) !== '0) begin
            n_fail++;
            $display("FAIL reset_x5 got %h/%h need 0", dat(1, 0), dat(0, 0));
        end
        if (busy_b[1] !== 1'b0 || busy_n[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_x6_busy got %b/%b need 0",
                     busy_b[1], busy_n[1]);
        end
    endtask

    task automatic test_basic();
        rd_adr[0 +: AW] = 5'd5;
        we = 2'b01; wr_adr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        #1;
        n_checks += 2;
        if (dat(0, 0) !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_nobyp_same got %h need 0", dat(0, 0));
        end
        if (dat(1, 0) !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_byp_same got %h need deadbeef", dat(1, 0));
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (dat(0, 0) !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_nobyp_next got %h need deadbeef", dat(0, 0));
        end
    endtask

    task automatic test_collision();
        rd_adr[0 +: AW] = 5'd7;
        we = 2'b11; wr_adr = {5'd7, 5'd7};
        wr_data = {32'h2222, 32'h1111};
        #1;
        n_checks += 2;
        if (dat(1, 0) !== 32'h2222) begin
            n_fail++;
            $display("FAIL coll_byp_same got %h need 2222", dat(1, 0));
        end
        if (dat(0, 0) !== 32'h0) begin
            n_fail++;
            $display("FAIL coll_nobyp_same got %h need 0", dat(0, 0));
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (dat(1, 0) !== 32'h2222 || dat(0, 0) !== 32'h2222) begin
            n_fail++;
            $display("FAIL coll_stored got %h/%h need 2222",
                     dat(1, 0), dat(0, 0));
        end
    endtask

    task automatic test_x0();
        rd_adr = '0;
        we = 2'b11; wr_adr = '0; wr_data = {64{1'b1}};
        sb_set = 1'b1; sb_adr = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (rd_data_b !== '0 || rd_data_n !== '0 ||
                busy_b !== '0 || busy_n !== '0) begin
                n_fail++;
                $display("FAIL x0 cyc %0d got %h/%h busy %b/%b need 0",
                         c, rd_data_b, rd_data_n, busy_b, busy_n);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_scoreboard();
        rd_adr[0 +: AW] = 5'd10;
        sb_set = 1'b1; sb_adr = 5'd10;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set got %b/%b need 1", busy_b[0], busy_n[0]);
        end
        we = 2'b10; wr_adr = {5'd10, 5'd0}; wr_data = {32'hA, 32'h0};
        sb_set = 1'b1; sb_adr = 5'd10;
        #1;
        n_checks++;
        if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_both_same got %b/%b need 0/1",
                     busy_b[0], busy_n[0]);
        end
        tick();
        sb_set = 1'b0;
        #1;
        n_checks++;
        if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_clr_same got %b/%b need 0/1",
                     busy_b[0], busy_n[0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clr_next got %b/%b need 0", busy_b[0], busy_n[0]);
        end
    endtask

    task automatic test_sweep();
        int shown = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++)
                rd_adr[i*AW +: AW] = AW'($urandom_range(0, (c & 1) ? 31 : 7));
            for (int j = 0; j < NW; j++) begin
                wr_adr[j*AW +: AW]  = AW'($urandom_range(0, (c & 2) ? 31 : 7));
                wr_data[j*XL +: XL] = $urandom;
            end
            we     = NW'($urandom);
            sb_set = ($urandom_range(0, 2) == 0);
            sb_adr = AW'($urandom_range(0, 7));
            #1;
            for (int i = 0; i < NR; i++) begin
                for (int b = 0; b < 2; b++) begin
                    logic [XL-1:0] gd;
                    logic          gb;
                    gd = dat(b[0], i);
                    gb = b[0] ? busy_b[i] : busy_n[i];
                    n_checks++;
                    if (gd !== exp_data(b[0], ra(i)) ||
                        gb !== exp_busy(b[0], ra(i))) begin
                        n_fail++;
                        if (shown < 20)
                            $display("FAIL sweep c%0d byp%0d p%0d x%0d got %h/%b need %h/%b",
                                     c, b, i, ra(i), gd, gb,
                                     exp_data(b[0], ra(i)), exp_busy(b[0], ra(i)));
                        shown++;
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b1;
        rd_adr = '0;
        idle();
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_collision();
        test_x0();
        test_scoreboard();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
